// File: rtl/riscv_trace_pkg.sv
// Shared types for the RISC-V commit-trace buffer: entry layout, kind bit positions
// and the saturating counter helper.
package riscv_trace_pkg;

  localparam int TRACE_DATA_W = 32;
  localparam int TRACE_ADDR_W = 9;
  localparam int TRACE_REG_W  = 5;
  localparam int TRACE_TS_W   = 16;
  localparam int KIND_W       = 3;

  localparam int KIND_REGWR = 0;
  localparam int KIND_MEMWR = 1;
  localparam int KIND_MEMRD = 2;

  typedef struct packed {
    logic [KIND_W-1:0]       kind;
    logic [TRACE_TS_W-1:0]   ts;
    logic [TRACE_REG_W-1:0]  reg_num;
    logic [TRACE_DATA_W-1:0] reg_data;
    logic [TRACE_ADDR_W-1:0] addr;
    logic [TRACE_DATA_W-1:0] mem_data;
  } trace_entry_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/trace_sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO; the head word reads as zero
// while empty so downstream fields never show stale data.
module trace_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;

  assign empty  = (count_r == '0);
  assign full   = (count_r == CNT_W'(DEPTH));
  assign pop_s  = pop & ~empty;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push_s = push & (~full | pop_s);
  assign count  = count_r;
  assign rdata  = empty ? '0 : mem_r[rd_ptr_r];

  // Pointer, occupancy and storage update; clear discards any concurrent push.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/riscv_trace_buffer.sv
// Commit-trace capture: detects register/memory retire events, packs them with a
// timestamp into a FIFO, and counts entries dropped when the FIFO is full.
module riscv_trace_buffer
  import riscv_trace_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 9,
  parameter int REG_W     = 5,
  parameter int DEPTH     = 16,
  parameter int TS_W      = 16,
  parameter int FILTER_X0 = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   clear,
  input  logic                   reg_write_sig,
  input  logic [REG_W-1:0]       reg_num,
  input  logic [DATA_W-1:0]      reg_data,
  input  logic                   wr,
  input  logic                   rd,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [DATA_W-1:0]      rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2:0]             out_kind,
  output logic [TS_W-1:0]        out_ts,
  output logic [REG_W-1:0]       out_reg_num,
  output logic [DATA_W-1:0]      out_reg_data,
  output logic [ADDR_W-1:0]      out_addr,
  output logic [DATA_W-1:0]      out_mem_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [15:0]            drop_cnt
);

  logic [TS_W-1:0] ts_r;
  logic            overflow_r;
  logic [15:0]     drop_cnt_r;
  logic            regwr_s;
  logic            event_s;
  logic            pop_s;
  logic            drop_s;
  logic            full_s;
  logic            empty_s;
  trace_entry_t    entry_s;
  trace_entry_t    head_s;

  assign regwr_s = reg_write_sig & ~((FILTER_X0 != 0) & (reg_num == '0));
  assign event_s = enable & (regwr_s | wr | rd);
  assign pop_s   = ~empty_s & out_ready;
  assign drop_s  = event_s & full_s & ~pop_s;

  // Pack the current cycle into an entry; fields of inactive kinds stay zero.
  always_comb begin
    entry_s                  = '0;
    entry_s.kind[KIND_REGWR] = regwr_s;
    entry_s.kind[KIND_MEMWR] = wr;
    entry_s.kind[KIND_MEMRD] = rd;
    entry_s.ts               = TRACE_TS_W'(ts_r);
    if (regwr_s) begin
      entry_s.reg_num  = TRACE_REG_W'(reg_num);
      entry_s.reg_data = TRACE_DATA_W'(reg_data);
    end else begin
      entry_s.reg_num  = '0;
      entry_s.reg_data = '0;
    end
    if (wr) begin
      entry_s.addr     = TRACE_ADDR_W'(addr);
      entry_s.mem_data = TRACE_DATA_W'(wr_data);
    end else if (rd) begin
      entry_s.addr     = TRACE_ADDR_W'(addr);
      entry_s.mem_data = TRACE_DATA_W'(rd_data);
    end else begin
      entry_s.addr     = '0;
      entry_s.mem_data = '0;
    end
  end

  trace_sync_fifo #(
    .WIDTH ($bits(trace_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (event_s),
    .pop   (pop_s),
    .wdata (entry_s),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count)
  );

  // Free-running timestamp and drop accounting; clear leaves the timestamp alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_r       <= '0;
      overflow_r <= 1'b0;
      drop_cnt_r <= 16'd0;
    end else begin
      ts_r <= ts_r + TS_W'(1);
      if (clear) begin
        overflow_r <= 1'b0;
        drop_cnt_r <= 16'd0;
      end else if (drop_s) begin
        overflow_r <= 1'b1;
        drop_cnt_r <= sat_inc16(drop_cnt_r);
      end
    end
  end

  assign out_valid    = ~empty_s;
  assign out_kind     = head_s.kind;
  assign out_ts       = TS_W'(head_s.ts);
  assign out_reg_num  = REG_W'(head_s.reg_num);
  assign out_reg_data = DATA_W'(head_s.reg_data);
  assign out_addr     = ADDR_W'(head_s.addr);
  assign out_mem_data = DATA_W'(head_s.mem_data);
  assign overflow     = overflow_r;
  assign drop_cnt     = drop_cnt_r;

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Directed self-checking bench for riscv_trace_buffer (default parameters).
module tb_riscv_trace_buffer;

  logic        clk = 1'b0;
  logic        reset, enable, clear;
  logic        reg_write_sig;
  logic [4:0]  reg_num;
  logic [31:0] reg_data;
  logic        wr, rd;
  logic [8:0]  addr;
  logic [31:0] wr_data, rd_data;
  logic        out_valid, out_ready;
  logic [2:0]  out_kind;
  logic [15:0] out_ts;
  logic [4:0]  out_reg_num;
  logic [31:0] out_reg_data;
  logic [8:0]  out_addr;
  logic [31:0] out_mem_data;
  logic [4:0]  count;
  logic        overflow;
  logic [15:0] drop_cnt;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] ts_now;
  logic [15:0] ts_first;

  riscv_trace_buffer dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .reg_write_sig(reg_write_sig), .reg_num(reg_num), .reg_data(reg_data),
    .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_ts(out_ts), .out_reg_num(out_reg_num), .out_reg_data(out_reg_data),
    .out_addr(out_addr), .out_mem_data(out_mem_data), .count(count),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs already set, outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    ts_now = ts_now + 16'd1;
  endtask

  task automatic idle();
    reg_write_sig = 1'b0; reg_num = 5'd0; reg_data = 32'd0;
    wr = 1'b0; rd = 1'b0; addr = 9'd0; wr_data = 32'd0; rd_data = 32'd0;
  endtask

  task automatic reg_ev(input logic [4:0] n, input logic [31:0] d);
    reg_write_sig = 1'b1; reg_num = n; reg_data = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"},    64'(out_valid),    64'd0);
    chk({tag, "_kind"},     64'(out_kind),     64'd0);
    chk({tag, "_ts"},       64'(out_ts),       64'd0);
    chk({tag, "_regnum"},   64'(out_reg_num),  64'd0);
    chk({tag, "_regdata"},  64'(out_reg_data), 64'd0);
    chk({tag, "_addr"},     64'(out_addr),     64'd0);
    chk({tag, "_memdata"},  64'(out_mem_data), 64'd0);
    chk({tag, "_count"},    64'(count),        64'd0);
    chk({tag, "_overflow"}, 64'(overflow),     64'd0);
    chk({tag, "_dropcnt"},  64'(drop_cnt),     64'd0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; clear = 1'b0; out_ready = 1'b0;
    ts_now = 16'd0;
    idle();
    step(); step();
    ts_now = 16'd0;
    chk_all_zero("reset");
    reset = 1'b0;

    // Single register write at ts=3.
    step(); step(); step();
    chk("ts_pre", 64'(ts_now), 64'd3);
    reg_ev(5'd5, 32'h0000_00AA);
    step();
    idle();
    chk("r1_valid",   64'(out_valid),    64'd1);
    chk("r1_kind",    64'(out_kind),     64'b001);
    chk("r1_regnum",  64'(out_reg_num),  64'd5);
    chk("r1_regdata", 64'(out_reg_data), 64'hAA);
    chk("r1_ts",      64'(out_ts),       64'd3);
    chk("r1_addr",    64'(out_addr),     64'd0);
    chk("r1_memdata", 64'(out_mem_data), 64'd0);
    chk("r1_count",   64'(count),        64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("r1_popped", 64'(out_valid), 64'd0);

    // wr+rd together with a filtered x0 write: ts now 5.
    wr = 1'b1; rd = 1'b1; addr = 9'h1F0; wr_data = 32'h1234; rd_data = 32'h5678;
    reg_ev(5'd0, 32'hDEAD_BEEF);
    step();
    idle();
    chk("m1_kind",    64'(out_kind),     64'b110);
    chk("m1_memdata", 64'(out_mem_data), 64'h1234);
    chk("m1_addr",    64'(out_addr),     64'h1F0);
    chk("m1_regnum",  64'(out_reg_num),  64'd0);
    chk("m1_regdata", 64'(out_reg_data), 64'd0);
    chk("m1_ts",      64'(out_ts),       64'd5);
    out_ready = 1'b1;
    // Read-only access enqueued while the previous head leaves.
    rd = 1'b1; addr = 9'h010; rd_data = 32'h5678;
    step();
    idle();
    out_ready = 1'b0;
    chk("m2_kind",    64'(out_kind),     64'b100);
    chk("m2_memdata", 64'(out_mem_data), 64'h5678);
    chk("m2_addr",    64'(out_addr),     64'h010);
    chk("m2_ts",      64'(out_ts),       64'd6);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("m2_empty", 64'(count), 64'd0);

    // 20 events with no consumer: 16 stored, 4 dropped.
    ts_first = ts_now;
    for (int i = 0; i < 20; i++) begin
      reg_ev(5'd1, 32'(i));
      step();
    end
    idle();
    chk("ov_count",    64'(count),    64'd16);
    chk("ov_overflow", 64'(overflow), 64'd1);
    chk("ov_dropcnt",  64'(drop_cnt), 64'd4);
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("drain_ts",   64'(out_ts),       64'(ts_first + 16'(k)));
      chk("drain_data", 64'(out_reg_data), 64'(k));
      step();
    end
    chk("drain_count", 64'(count), 64'd0);
    step();
    chk("idle_count", 64'(count),     64'd0);
    chk("idle_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 16; i++) begin
      reg_ev(5'd2, 32'(100 + i));
      step();
    end
    chk("fp_full", 64'(count), 64'd16);
    out_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      reg_ev(5'd3, 32'(200 + j));
      chk("fp_head", 64'(out_reg_data), 64'(100 + j));
      step();
    end
    idle();
    out_ready = 1'b0;
    chk("fp_count",   64'(count),        64'd16);
    chk("fp_dropcnt", 64'(drop_cnt),     64'd4);
    chk("fp_next",    64'(out_reg_data), 64'd110);
    step();
    chk("fp_stable", 64'(out_reg_data), 64'd110);

    // Clear with a concurrent event at count=7.
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) step();
    out_ready = 1'b0;
    chk("cl_pre_count",    64'(count),    64'd7);
    chk("cl_pre_overflow", 64'(overflow), 64'd1);
    clear = 1'b1;
    reg_ev(5'd4, 32'h4444);
    step();
    clear = 1'b0;
    idle();
    chk("cl_count",    64'(count),     64'd0);
    chk("cl_valid",    64'(out_valid), 64'd0);
    chk("cl_overflow", 64'(overflow),  64'd0);
    chk("cl_dropcnt",  64'(drop_cnt),  64'd0);
    step();
    chk("cl_nostore", 64'(count), 64'd0);

    // Reset in the middle of a drain at count=9.
    for (int i = 0; i < 11; i++) begin
      reg_ev(5'd6, 32'(i));
      step();
    end
    idle();
    out_ready = 1'b1;
    step(); step();
    chk("rd_pre_count", 64'(count), 64'd9);
    reset = 1'b1;
    step();
    ts_now = 16'd0;
    chk_all_zero("rst_mid");
    reset = 1'b0;
    // Push into an empty FIFO while out_ready is high: pop is ignored.
    reg_ev(5'd7, 32'h77);
    step();
    out_ready = 1'b0;
    chk("rs_count", 64'(count),    64'd1);
    chk("rs_ts",    64'(out_ts),   64'd0);
    chk("rs_kind",  64'(out_kind), 64'b001);
    for (int i = 0; i < 15; i++) begin
      reg_ev(5'd8, 32'(i));
      step();
    end
    enable = 1'b0;
    wr = 1'b1; addr = 9'h055; wr_data = 32'h55;
    for (int i = 0; i < 5; i++) step();
    idle();
    chk("en_count",    64'(count),    64'd16);
    chk("en_dropcnt",  64'(drop_cnt), 64'd0);
    chk("en_overflow", 64'(overflow), 64'd0);
    chk("en_head_ts",  64'(out_ts),   64'd0);
    out_ready = 1'b1;
    reg_ev(5'd9, 32'h99);
    step(); step(); step();
    idle();
    out_ready = 1'b0;
    chk("en_drain", 64'(count), 64'd13);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
